// File: rtl/mips_regfile_if.sv
// Register-file access bundle: one write port, two operand read ports, a debug
// read port and the committed-write counter.
interface mips_regfile_if #(
    parameter int WIDTH = 32
);
    logic             we;
    logic [4:0]       raddr1;
    logic [4:0]       raddr2;
    logic [4:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic [4:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;
    logic [15:0]      wr_count;

    modport master (
        output we, raddr1, raddr2, waddr, wdata, dbg_addr,
        input  rdata1, rdata2, dbg_data, wr_count
    );

    modport slave (
        input  we, raddr1, raddr2, waddr, wdata, dbg_addr,
        output rdata1, rdata2, dbg_data, wr_count
    );
endinterface

// File: rtl/mips_regfile.sv
// 32 x WIDTH MIPS general-purpose register file: $0 hardwired to zero, two
// combinational operand reads, one synchronous write, debug read, write counter.
module mips_regfile #(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    mips_regfile_if.slave  rf
);

    logic [WIDTH-1:0] regs [1:31];
    logic [15:0]      wr_count_q;
    logic             commit;
    logic             byp1;
    logic             byp2;

    // The we gate comes first so an unknown waddr with we=0 cannot commit.
    assign commit = rf.we && (rf.waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
            wr_count_q <= '0;
        end else if (commit) begin
            regs[rf.waddr] <= rf.wdata;
            if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign byp1 = BYPASS && rf.we && !rst && (rf.waddr == rf.raddr1);
    assign byp2 = BYPASS && rf.we && !rst && (rf.waddr == rf.raddr2);

    always_comb begin
        rf.rdata1 = '0;
        if (rf.raddr1 != 5'd0) rf.rdata1 = byp1 ? rf.wdata : regs[rf.raddr1];
    end

    always_comb begin
        rf.rdata2 = '0;
        if (rf.raddr2 != 5'd0) rf.rdata2 = byp2 ? rf.wdata : regs[rf.raddr2];
    end

    always_comb begin
        rf.dbg_data = '0;
        if (rf.dbg_addr != 5'd0) rf.dbg_data = regs[rf.dbg_addr];
    end

    assign rf.wr_count = wr_count_q;

endmodule

// File: tb/tb_mips_regfile.sv
// Directed bench for mips_regfile: a no-bypass and a bypass instance share one
// stimulus stream; table vectors plus hand sequences for jal, reset and saturation.
module tb_mips_regfile;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_regfile_if #(.WIDTH(32)) rf0 ();
    mips_regfile_if #(.WIDTH(32)) rf1 ();

    assign rf1.we       = rf0.we;
    assign rf1.raddr1   = rf0.raddr1;
    assign rf1.raddr2   = rf0.raddr2;
    assign rf1.waddr    = rf0.waddr;
    assign rf1.wdata    = rf0.wdata;
    assign rf1.dbg_addr = rf0.dbg_addr;

    mips_regfile #(.WIDTH(32), .BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .rf(rf0));
    mips_regfile #(.WIDTH(32), .BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .rf(rf1));

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  da;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
        logic [15:0] ec;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] model [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            rf0.dbg_addr = 5'(a);
            rf0.raddr1   = 5'(a);
            rf0.raddr2   = 5'(a);
            #1;
            check({tag, " dbg0"}, rf0.dbg_data, 32'h0);
            check({tag, " dbg1"}, rf1.dbg_data, 32'h0);
            check({tag, " rd1"},  rf0.rdata1,   32'h0);
            check({tag, " rd2"},  rf1.rdata2,   32'h0);
        end
        check({tag, " cnt0"}, {16'h0, rf0.wr_count}, 32'h0);
        check({tag, " cnt1"}, {16'h0, rf1.wr_count}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        16'd1};
        vecs[2] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd5,  5'd31, 32'h1,        32'hDEADBEEF, 32'h1,        16'd2};
        vecs[3] = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd31, 5'd5,  32'hDEADBEEF, 32'h1,        32'hDEADBEEF, 16'd2};
        vecs[4] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 16'd3};
        vecs[5] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd7,  5'd0,  32'hCAFEF00D, 32'h12345678, 32'h0,        16'd4};
        vecs[6] = '{1'b0, 5'bx,  32'hx,        5'd5,  5'd7,  5'd31, 32'hCAFEF00D, 32'h12345678, 32'h1,        16'd4};

        rst = 1'b1;
        rf0.we = 1'b0; rf0.waddr = '0; rf0.wdata = '0;
        rf0.raddr1 = '0; rf0.raddr2 = '0; rf0.dbg_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Write on the edge, then read back with we low so both instances agree.
        for (int v = 0; v < 7; v++) begin
            rf0.we = vecs[v].we; rf0.waddr = vecs[v].waddr; rf0.wdata = vecs[v].wdata;
            tick();
            rf0.we = 1'b0;
            rf0.raddr1 = vecs[v].ra1; rf0.raddr2 = vecs[v].ra2; rf0.dbg_addr = vecs[v].da;
            #1;
            check($sformatf("vec%0d rd1_nb", v), rf0.rdata1, vecs[v].e1);
            check($sformatf("vec%0d rd2_nb", v), rf0.rdata2, vecs[v].e2);
            check($sformatf("vec%0d rd1_bp", v), rf1.rdata1, vecs[v].e1);
            check($sformatf("vec%0d rd2_bp", v), rf1.rdata2, vecs[v].e2);
            check($sformatf("vec%0d dbg",    v), rf0.dbg_data, vecs[v].ed);
            check($sformatf("vec%0d cnt",    v), {16'h0, rf0.wr_count}, {16'h0, vecs[v].ec});
        end

        // jal: reg31 holds 1; look at it mid-cycle while the write is pending.
        rf0.we = 1'b1; rf0.waddr = 5'd31; rf0.wdata = 32'h00400008;
        rf0.raddr1 = 5'd0; rf0.raddr2 = 5'd31; rf0.dbg_addr = 5'd31;
        #1;
        check("jal rd2 nobypass", rf0.rdata2, 32'h1);
        check("jal rd2 bypass",   rf1.rdata2, 32'h00400008);
        check("jal dbg bypass",   rf1.dbg_data, 32'h1);
        check("jal rd1 zero",     rf1.rdata1, 32'h0);
        tick();
        rf0.we = 1'b0;
        #1;
        check("jal dbg after",  rf0.dbg_data, 32'h00400008);
        check("jal rd2 after",  rf0.rdata2, 32'h00400008);
        check("jal cnt",        {16'h0, rf0.wr_count}, 32'd5);

        // Bypass never applies to $0.
        rf0.we = 1'b1; rf0.waddr = 5'd0; rf0.wdata = 32'h5A5A5A5A; rf0.raddr1 = 5'd0;
        #1;
        check("byp r0", rf1.rdata1, 32'h0);
        tick();
        check("byp r0 cnt", {16'h0, rf1.wr_count}, 32'd5);

        // Reset and write on the same edge: reset wins, and no bypass under reset.
        rf0.we = 1'b1; rf0.waddr = 5'd7; rf0.wdata = 32'hAAAA5555;
        rf0.raddr1 = 5'd7; rf0.dbg_addr = 5'd7;
        rst = 1'b1;
        #1;
        check("rst no bypass", rf1.rdata1, 32'h12345678);
        tick();
        rst = 1'b0; rf0.we = 1'b0;
        #1;
        check("rst reg7 nb", rf0.dbg_data, 32'h0);
        check("rst reg7 bp", rf1.rdata1, 32'h0);
        check_all_zero("rst+we");

        // Saturation run with a scoreboard of the last value per register.
        for (int a = 0; a < 32; a++) model[a] = 32'h0;
        rf0.we = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            rf0.waddr = 5'((i % 31) + 1);
            rf0.wdata = i;
            model[(i % 31) + 1] = i;
            tick();
        end
        check("cnt fffe", {16'h0, rf0.wr_count}, 32'h0000FFFE);
        for (int i = 65534; i < 65537; i++) begin
            rf0.waddr = 5'((i % 31) + 1);
            rf0.wdata = i;
            model[(i % 31) + 1] = i;
            tick();
            check($sformatf("cnt sat %0d", i), {16'h0, rf0.wr_count}, 32'h0000FFFF);
        end
        rf0.we = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rf0.waddr = 5'($urandom_range(31, 1));
            rf0.wdata = $urandom;
            tick();
        end
        for (int a = 0; a < 32; a++) begin
            rf0.dbg_addr = 5'(a);
            rf0.raddr1   = 5'(a);
            #1;
            check($sformatf("hold dbg%0d", a), rf0.dbg_data, model[a]);
            check($sformatf("hold rd1_%0d", a), rf1.rdata1, model[a]);
        end
        check("cnt hold", {16'h0, rf1.wr_count}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
